// File: rtl/parking_meter_pkg.sv
// Shared constants, button ordering and the saturating add used by the
// parking-meter time sequencer.
package parking_meter_pkg;

    localparam int TIME_W  = 14;
    localparam int NUM_BTN = 6;

    localparam logic [TIME_W-1:0] MAX_VAL  = 14'd9999;
    localparam logic [TIME_W-1:0] LOW_TH   = 14'd200;

    localparam logic [TIME_W-1:0] LD_R10   = 14'd10;
    localparam logic [TIME_W-1:0] LD_R205  = 14'd205;

    localparam logic [TIME_W-1:0] ADD_A50  = 14'd50;
    localparam logic [TIME_W-1:0] ADD_A150 = 14'd150;
    localparam logic [TIME_W-1:0] ADD_A200 = 14'd200;
    localparam logic [TIME_W-1:0] ADD_A500 = 14'd500;

    // Lowest index wins when several buttons fire on the same edge.
    typedef enum logic [2:0] {
        BTN_R10,
        BTN_R205,
        BTN_A50,
        BTN_A150,
        BTN_A200,
        BTN_A500
    } btn_e;

    function automatic logic [TIME_W-1:0] sat_add(
        input logic [TIME_W-1:0] base,
        input logic [TIME_W-1:0] n
    );
        logic [TIME_W:0] sum;
        sum = {1'b0, base} + {1'b0, n};
        return (sum >= {1'b0, MAX_VAL}) ? MAX_VAL : sum[TIME_W-1:0];
    endfunction

endpackage

// File: rtl/parking_meter_if.sv
// Button levels in, remaining time and display status out.
// master = button/display side, slave = the sequencer.
interface parking_meter_if;
    import parking_meter_pkg::*;

    logic              btn_r10;
    logic              btn_r205;
    logic              btn_a50;
    logic              btn_a150;
    logic              btn_a200;
    logic              btn_a500;
    logic [TIME_W-1:0] time_val;
    logic              disp_on;
    logic              expired;
    logic              sec_tick;

    modport master (
        output btn_r10, btn_r205, btn_a50,
        output btn_a150, btn_a200, btn_a500,
        input  time_val, disp_on, expired, sec_tick
    );

    modport slave (
        input  btn_r10, btn_r205, btn_a50,
        input  btn_a150, btn_a200, btn_a500,
        output time_val, disp_on, expired, sec_tick
    );

endinterface

// File: rtl/parking_meter_ctrl_tick_gen.sv
// One-second prescaler with half-second phase and second parity.
// A restart drops everything back to the start of a fresh second.
module pm_tick_gen #(
    parameter int TICK_DIV = 100_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart_i,
    output logic tick_o,
    output logic half_d_o,
    output logic par_d_o
);
    localparam int CW = $clog2(TICK_DIV);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          half_q, half_d;
    logic          par_q, par_d;
    logic          wrap, mid;

    assign wrap = (cnt_q == CW'(TICK_DIV - 1));
    assign mid  = (cnt_q == CW'(TICK_DIV / 2 - 1));

    // Advance the count; flip phase at each half second, parity each second.
    always_comb begin
        cnt_d  = wrap ? '0 : cnt_q + CW'(1);
        half_d = half_q ^ (wrap | mid);
        par_d  = par_q ^ wrap;
        if (restart_i) begin
            cnt_d  = '0;
            half_d = 1'b0;
            par_d  = 1'b0;
        end
    end

    // Prescaler state with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            half_q <= 1'b0;
            par_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            half_q <= half_d;
            par_q  <= par_d;
        end
    end

    assign tick_o   = wrap;
    assign half_d_o = half_d;
    assign par_d_o  = par_d;

endmodule

// File: rtl/parking_meter_ctrl.sv
// Parking-meter time sequencer: owns the remaining-time register,
// applies one button command per edge and drives blink/expiry status.
module parking_meter_ctrl
    import parking_meter_pkg::*;
#(
    parameter int TICK_DIV = 100_000_000
) (
    input  logic           clk,
    input  logic           rst_n,
    parking_meter_if.slave pm
);
    logic [NUM_BTN-1:0] btn, b_q, p, sel;
    logic [TIME_W-1:0]  time_q, time_d, base, add;
    logic               load, tick, half_d, par_d;
    logic               disp_q, disp_d, exp_q, exp_d;

    assign btn = {pm.btn_a500, pm.btn_a200, pm.btn_a150,
                  pm.btn_a50, pm.btn_r205, pm.btn_r10};
    assign p   = btn & ~b_q;
    assign sel = p & (~p + NUM_BTN'(1));

    // The decrement is folded in before any add, and never goes below 0.
    assign base = (tick && time_q != '0) ? time_q - TIME_W'(1) : time_q;

    pm_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk       (clk),
        .rst_n     (rst_n),
        .restart_i (load),
        .tick_o    (tick),
        .half_d_o  (half_d),
        .par_d_o   (par_d)
    );

    // Winning button selects a reload or a saturating add on top of base.
    always_comb begin
        load   = 1'b0;
        add    = '0;
        time_d = base;
        unique case (1'b1)
            sel[BTN_R10]:  begin load = 1'b1; time_d = LD_R10;  end
            sel[BTN_R205]: begin load = 1'b1; time_d = LD_R205; end
            sel[BTN_A50]:  add = ADD_A50;
            sel[BTN_A150]: add = ADD_A150;
            sel[BTN_A200]: add = ADD_A200;
            sel[BTN_A500]: add = ADD_A500;
            default: ;
        endcase
        if (!load) time_d = sat_add(base, add);
    end

    // Status is derived from the values the time and phase registers take next.
    always_comb begin
        exp_d  = (time_d == '0);
        disp_d = 1'b1;
        if (time_d == '0)
            disp_d = ~half_d;
        else if (time_d < LOW_TH)
            disp_d = ~par_d;
    end

    // Time, button history and status registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            b_q    <= '0;
            time_q <= '0;
            exp_q  <= 1'b1;
            disp_q <= 1'b1;
        end else begin
            b_q    <= btn;
            time_q <= time_d;
            exp_q  <= exp_d;
            disp_q <= disp_d;
        end
    end

    assign pm.time_val = time_q;
    assign pm.disp_on  = disp_q;
    assign pm.expired  = exp_q;
    assign pm.sec_tick = tick;

endmodule

// File: tb/tb_parking_meter_ctrl.sv
// Directed bench for parking_meter_ctrl with a 10-cycle second.
// Inputs change and outputs are sampled on the falling edge.
module tb_parking_meter_ctrl;
    import parking_meter_pkg::*;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [NUM_BTN-1:0] btn;
    int                 checks = 0;
    int                 errors = 0;

    parking_meter_if pmif ();

    assign pmif.btn_r10  = btn[BTN_R10];
    assign pmif.btn_r205 = btn[BTN_R205];
    assign pmif.btn_a50  = btn[BTN_A50];
    assign pmif.btn_a150 = btn[BTN_A150];
    assign pmif.btn_a200 = btn[BTN_A200];
    assign pmif.btn_a500 = btn[BTN_A500];

    parking_meter_ctrl #(
        .TICK_DIV (10)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .pm    (pmif.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic press(input btn_e b);
        btn[b] = 1'b1;
        @(negedge clk);
        btn[b] = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [16:0] got, ev;
        rst_n = 1'b0;
        btn   = '0;
        repeat (3) @(negedge clk);
        got = {pmif.time_val, pmif.disp_on, pmif.expired, pmif.sec_tick};
        ev  = {14'd0, 1'b1, 1'b1, 1'b0};
        checks++;
        if (got !== ev) begin
            errors++;
            $display("FAIL reset got %h exp %h", got, ev);
        end
        rst_n = 1'b1;
        for (int k = 1; k <= 25; k++) begin
            @(negedge clk);
            got = {pmif.time_val, pmif.disp_on, pmif.expired, pmif.sec_tick};
            ev  = {14'd0, 1'((k / 5) % 2 == 0), 1'b1, 1'(k % 10 == 9)};
            checks++;
            if (got !== ev) begin
                errors++;
                $display("FAIL idle k=%0d got %h exp %h", k, got, ev);
            end
        end
    endtask

    task automatic test_load205();
        logic [16:0] got, ev;
        btn[BTN_R205] = 1'b1;
        @(negedge clk);
        btn[BTN_R205] = 1'b0;
        for (int j = 0; j <= 30; j++) begin
            if (j > 0) @(negedge clk);
            got = {pmif.time_val, pmif.disp_on, pmif.expired, pmif.sec_tick};
            ev  = {14'(205 - j / 10), 1'b1, 1'b0, 1'(j % 10 == 9)};
            checks++;
            if (got !== ev) begin
                errors++;
                $display("FAIL load205 j=%0d got %h exp %h", j, got, ev);
            end
        end
    endtask

    task automatic test_saturate();
        logic [16:0] got, ev;
        press(BTN_R10);
        checks++;
        if (pmif.time_val !== 14'd10) begin
            errors++;
            $display("FAIL sat_load time got %0d exp 10", pmif.time_val);
        end
        for (int k = 0; k < 20; k++) begin
            press(BTN_A500);
            if (k == 1) begin
                checks++;
                if (pmif.time_val !== 14'd1010) begin
                    errors++;
                    $display("FAIL sat_add2 time got %0d exp 1010", pmif.time_val);
                end
            end
        end
        checks++;
        if (pmif.time_val !== 14'd9999) begin
            errors++;
            $display("FAIL sat_top time got %0d exp 9999", pmif.time_val);
        end
        press(BTN_A50);
        checks++;
        if (pmif.time_val !== 14'd9999) begin
            errors++;
            $display("FAIL sat_a50 time got %0d exp 9999", pmif.time_val);
        end
        repeat (6) @(negedge clk);
        got = {pmif.time_val, pmif.disp_on, pmif.expired, pmif.sec_tick};
        ev  = {14'd9999, 1'b1, 1'b0, 1'b1};
        checks++;
        if (got !== ev) begin
            errors++;
            $display("FAIL sat_pretick got %h exp %h", got, ev);
        end
        @(negedge clk);
        got = {pmif.time_val, pmif.disp_on, pmif.expired, pmif.sec_tick};
        ev  = {14'd9998, 1'b1, 1'b0, 1'b0};
        checks++;
        if (got !== ev) begin
            errors++;
            $display("FAIL sat_dec got %h exp %h", got, ev);
        end
    endtask

    task automatic test_priority();
        press(BTN_R10);
        repeat (99) @(negedge clk);
        checks++;
        if ({pmif.time_val, pmif.expired} !== {14'd0, 1'b1}) begin
            errors++;
            $display("FAIL prio_zero time %0d exp %b, want 0/1",
                     pmif.time_val, pmif.expired);
        end
        press(BTN_A50);
        checks++;
        if ({pmif.time_val, pmif.expired} !== {14'd50, 1'b0}) begin
            errors++;
            $display("FAIL prio_from0 time %0d exp %b, want 50/0",
                     pmif.time_val, pmif.expired);
        end
        press(BTN_A50);
        btn[BTN_A50]  = 1'b1;
        btn[BTN_A500] = 1'b1;
        @(negedge clk);
        btn = '0;
        checks++;
        if (pmif.time_val !== 14'd150) begin
            errors++;
            $display("FAIL prio_a50_a500 time got %0d exp 150", pmif.time_val);
        end
        @(negedge clk);
        btn[BTN_R10]  = 1'b1;
        btn[BTN_A500] = 1'b1;
        @(negedge clk);
        btn = '0;
        checks++;
        if (pmif.time_val !== 14'd10) begin
            errors++;
            $display("FAIL prio_r10_a500 time got %0d exp 10", pmif.time_val);
        end
        @(negedge clk);
        btn[BTN_A50] = 1'b1;
        @(negedge clk);
        checks++;
        if (pmif.time_val !== 14'd60) begin
            errors++;
            $display("FAIL hold_first time got %0d exp 60", pmif.time_val);
        end
        repeat (29) @(negedge clk);
        btn[BTN_A50] = 1'b0;
        checks++;
        if (pmif.time_val !== 14'd57) begin
            errors++;
            $display("FAIL hold_end time got %0d exp 57", pmif.time_val);
        end
        @(negedge clk);
        checks++;
        if (pmif.time_val !== 14'd57) begin
            errors++;
            $display("FAIL hold_release time got %0d exp 57", pmif.time_val);
        end
    endtask

    task automatic test_low_blink();
        logic [16:0] got, ev;
        logic [13:0] et;
        press(BTN_R205);
        for (int j = 1; j <= 89; j++) begin
            if (j > 1) @(negedge clk);
            et  = 14'(205 - j / 10);
            got = {pmif.time_val, pmif.disp_on, pmif.expired, pmif.sec_tick};
            ev  = {et, 1'(et >= 14'd200 || (j / 10) % 2 == 0), 1'b0,
                   1'(j % 10 == 9)};
            checks++;
            if (got !== ev) begin
                errors++;
                $display("FAIL low_blink j=%0d got %h exp %h", j, got, ev);
            end
        end
    endtask

    task automatic test_expire_blink();
        logic [16:0] got, ev;
        logic [13:0] et;
        logic        ed;
        press(BTN_R10);
        for (int j = 1; j <= 119; j++) begin
            if (j > 1) @(negedge clk);
            et  = (j < 100) ? 14'(10 - j / 10) : 14'd0;
            ed  = (et == 14'd0) ? 1'((j / 5) % 2 == 0) : 1'((j / 10) % 2 == 0);
            got = {pmif.time_val, pmif.disp_on, pmif.expired, pmif.sec_tick};
            ev  = {et, ed, 1'(et == 14'd0), 1'(j % 10 == 9)};
            checks++;
            if (got !== ev) begin
                errors++;
                $display("FAIL expire j=%0d got %h exp %h", j, got, ev);
            end
        end
    endtask

    task automatic test_tick_add_reset();
        logic [16:0] got, ev;
        press(BTN_R10);
        repeat (99) @(negedge clk);
        press(BTN_A50);
        press(BTN_A50);
        repeat (5) @(negedge clk);
        got = {pmif.time_val, pmif.disp_on, pmif.expired, pmif.sec_tick};
        ev  = {14'd100, 1'b1, 1'b0, 1'b1};
        checks++;
        if (got !== ev) begin
            errors++;
            $display("FAIL tick_add_pre got %h exp %h", got, ev);
        end
        btn[BTN_A150] = 1'b1;
        @(negedge clk);
        btn[BTN_A150] = 1'b0;
        got = {pmif.time_val, pmif.disp_on, pmif.expired, pmif.sec_tick};
        ev  = {14'd249, 1'b1, 1'b0, 1'b0};
        checks++;
        if (got !== ev) begin
            errors++;
            $display("FAIL tick_add got %h exp %h", got, ev);
        end
        press(BTN_A200);
        press(BTN_A50);
        checks++;
        if (pmif.time_val !== 14'd499) begin
            errors++;
            $display("FAIL pre_reset time got %0d exp 499", pmif.time_val);
        end
        rst_n = 1'b0;
        @(negedge clk);
        got = {pmif.time_val, pmif.disp_on, pmif.expired, pmif.sec_tick};
        ev  = {14'd0, 1'b1, 1'b1, 1'b0};
        checks++;
        if (got !== ev) begin
            errors++;
            $display("FAIL mid_reset got %h exp %h", got, ev);
        end
        rst_n = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            got = {pmif.time_val, pmif.disp_on, pmif.expired, pmif.sec_tick};
            ev  = {14'd0, 1'((k / 5) % 2 == 0), 1'b1, 1'(k == 9)};
            checks++;
            if (got !== ev) begin
                errors++;
                $display("FAIL post_reset k=%0d got %h exp %h", k, got, ev);
            end
        end
    endtask

    initial begin
        test_reset();
        test_load205();
        test_saturate();
        test_priority();
        test_low_blink();
        test_expire_blink();
        test_tick_add_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
